// File: rtl/sched_pkg.sv
// Shared helpers for the fire scheduler: index width, LFSR taps and step,
// and the "no transition" sentinel value.
package sched_pkg;

  // Galois taps for x^8+x^6+x^5+x^4+1 (maximal length, right-shifting)
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Bits needed to encode 0..nt (nt itself is the "none" code)
  function automatic int fw_of(input int nt);
    return $clog2(nt + 1);
  endfunction

  // Index value meaning "nothing selected"
  function automatic int sentinel(input int nt);
    return nt;
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotated priority pick: first set bit of vec scanning start..N-1 then 0..start-1.
// Ports: vec, start (must be < N) in; idx (N when none), found out. Combinational.
module rr_pick
  import sched_pkg::*;
#(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [N-1:0] rot;

  always_comb begin
    rot   = N'({vec, vec} >> start);
    idx   = W'(sentinel(N));
    found = 1'b0;
    // Descending so the smallest offset from start wins
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        if (int'(start) + i >= N)
          idx = start - W'(N - i);
        else
          idx = start + W'(i);
      end
    end
  end

endmodule

// File: rtl/fire_scheduler.sv
// Picks one enabled transition per cycle (round-robin or LFSR start point).
// Ports: clk, reset, in_req, gate_ena, mode, hold in; fire, fire_valid, deadlock, idle_cnt out.
module fire_scheduler
  import sched_pkg::*;
#(
  parameter int         N_IN     = 2,
  parameter int         N_ST     = 3,
  parameter int         DL_LIMIT = 16,
  parameter logic [7:0] SEED     = 8'hA5,
  localparam int        NT       = N_IN + N_ST,
  localparam int        FW       = fw_of(NT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_IN-1:0] in_req,
  input  logic [N_ST-1:0] gate_ena,
  input  logic            mode,
  input  logic            hold,
  output logic [FW-1:0]   fire,
  output logic            fire_valid,
  output logic            deadlock,
  output logic [7:0]      idle_cnt
);

  logic [NT-1:0] ena;
  logic [FW-1:0] ptr;
  logic [FW-1:0] start;
  logic [FW-1:0] pick;
  logic          found;
  logic [7:0]    lfsr;
  logic [7:0]    idle_nxt;

  assign ena   = {gate_ena, in_req};
  assign start = mode ? FW'(int'(lfsr) % NT) : ptr;

  rr_pick #(
    .N(NT),
    .W(FW)
  ) u_pick (
    .vec  (ena),
    .start(start),
    .idx  (pick),
    .found(found)
  );

  // Reset gates the output directly so it drops without waiting for a clock
  assign fire_valid = found & ~hold & ~reset;
  assign fire       = fire_valid ? pick : FW'(sentinel(NT));

  always_comb begin
    idle_nxt = idle_cnt;
    if (ena == '0) begin
      if (idle_cnt != 8'hFF)
        idle_nxt = idle_cnt + 8'd1;
    end else begin
      idle_nxt = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr      <= '0;
      lfsr     <= SEED;
      idle_cnt <= 8'd0;
      deadlock <= 1'b0;
    end else begin
      // Pointer tracks grants in both modes so round-robin resumes fairly
      if (fire_valid)
        ptr <= (fire == FW'(NT - 1)) ? '0 : fire + FW'(1);
      if (!hold) begin
        lfsr     <= lfsr_next(lfsr);
        idle_cnt <= idle_nxt;
        if (idle_nxt >= 8'(DL_LIMIT))
          deadlock <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fire_scheduler.sv
// Directed bench for fire_scheduler with N_IN=2, N_ST=3, DL_LIMIT=4.
// Table rows plus hand sequences for hold, mid-cycle reset and LFSR mode.
module tb_fire_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] in_req = '0;
  logic [2:0] gate_ena = '0;
  logic       mode = 1'b0;
  logic       hold = 1'b0;
  logic [2:0] fire;
  logic       fire_valid;
  logic       deadlock;
  logic [7:0] idle_cnt;

  int checks = 0;
  int errors = 0;

  fire_scheduler #(
    .N_IN(2),
    .N_ST(3),
    .DL_LIMIT(4),
    .SEED(8'hA5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_req    (in_req),
    .gate_ena  (gate_ena),
    .mode      (mode),
    .hold      (hold),
    .fire      (fire),
    .fire_valid(fire_valid),
    .deadlock  (deadlock),
    .idle_cnt  (idle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] in_req;
    logic [2:0] gate;
    logic       mode;
    logic       hold;
    logic [2:0] fire;
    logic       valid;
    logic [7:0] idle;
    logic       dl;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Entered and left at a negedge
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_fire", 32'(fire), 5);
    chk("rst_valid", 32'(fire_valid), 0);
    chk("rst_idle", 32'(idle_cnt), 0);
    chk("rst_dl", 32'(deadlock), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Entered and left at a negedge; one clock per call
  task automatic apply(input logic [1:0] ir, input logic [2:0] ge,
                       input logic md, input logic hd,
                       input logic [2:0] ef, input logic ev,
                       input logic [7:0] ei, input logic ed);
    in_req   = ir;
    gate_ena = ge;
    mode     = md;
    hold     = hd;
    #1;
    chk("fire", 32'(fire), 32'(ef));
    chk("valid", 32'(fire_valid), 32'(ev));
    @(posedge clk);
    #1;
    chk("idle", 32'(idle_cnt), 32'(ei));
    chk("deadlock", 32'(deadlock), 32'(ed));
    @(negedge clk);
  endtask

  initial begin
    // Two requests only, round-robin from 0
    tbl.push_back('{1'b1, 2'b11, 3'b000, 1'b0, 1'b0, 3'd0, 1'b1, 8'd0, 1'b0});
    tbl.push_back('{1'b0, 2'b11, 3'b000, 1'b0, 1'b0, 3'd1, 1'b1, 8'd0, 1'b0});
    tbl.push_back('{1'b0, 2'b11, 3'b000, 1'b0, 1'b0, 3'd0, 1'b1, 8'd0, 1'b0});
    tbl.push_back('{1'b0, 2'b11, 3'b000, 1'b0, 1'b0, 3'd1, 1'b1, 8'd0, 1'b0});
    // All enabled: full rotation
    tbl.push_back('{1'b1, 2'b11, 3'b111, 1'b0, 1'b0, 3'd0, 1'b1, 8'd0, 1'b0});
    tbl.push_back('{1'b0, 2'b11, 3'b111, 1'b0, 1'b0, 3'd1, 1'b1, 8'd0, 1'b0});
    tbl.push_back('{1'b0, 2'b11, 3'b111, 1'b0, 1'b0, 3'd2, 1'b1, 8'd0, 1'b0});
    tbl.push_back('{1'b0, 2'b11, 3'b111, 1'b0, 1'b0, 3'd3, 1'b1, 8'd0, 1'b0});
    tbl.push_back('{1'b0, 2'b11, 3'b111, 1'b0, 1'b0, 3'd4, 1'b1, 8'd0, 1'b0});
    tbl.push_back('{1'b0, 2'b11, 3'b111, 1'b0, 1'b0, 3'd0, 1'b1, 8'd0, 1'b0});
    // Nothing enabled: count up to deadlock, which then sticks
    tbl.push_back('{1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 3'd5, 1'b0, 8'd1, 1'b0});
    tbl.push_back('{1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 3'd5, 1'b0, 8'd2, 1'b0});
    tbl.push_back('{1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 3'd5, 1'b0, 8'd3, 1'b0});
    tbl.push_back('{1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 3'd5, 1'b0, 8'd4, 1'b1});
    tbl.push_back('{1'b0, 2'b01, 3'b000, 1'b0, 1'b0, 3'd0, 1'b1, 8'd0, 1'b1});
    tbl.push_back('{1'b0, 2'b10, 3'b000, 1'b0, 1'b0, 3'd1, 1'b1, 8'd0, 1'b1});
    tbl.push_back('{1'b0, 2'b10, 3'b000, 1'b0, 1'b0, 3'd1, 1'b1, 8'd0, 1'b1});
    // LFSR start: A5%5=0, EA%5=4, 75%5=2, 82%5=0; then back to pointer (1)
    tbl.push_back('{1'b1, 2'b11, 3'b111, 1'b1, 1'b0, 3'd0, 1'b1, 8'd0, 1'b0});
    tbl.push_back('{1'b0, 2'b11, 3'b111, 1'b1, 1'b0, 3'd4, 1'b1, 8'd0, 1'b0});
    tbl.push_back('{1'b0, 2'b11, 3'b111, 1'b1, 1'b0, 3'd2, 1'b1, 8'd0, 1'b0});
    tbl.push_back('{1'b0, 2'b11, 3'b111, 1'b1, 1'b0, 3'd0, 1'b1, 8'd0, 1'b0});
    tbl.push_back('{1'b0, 2'b11, 3'b111, 1'b0, 1'b0, 3'd1, 1'b1, 8'd0, 1'b0});
    // Hold: pointer reaches 3, frozen through hold, then resumes at 3
    tbl.push_back('{1'b1, 2'b11, 3'b111, 1'b0, 1'b0, 3'd0, 1'b1, 8'd0, 1'b0});
    tbl.push_back('{1'b0, 2'b11, 3'b111, 1'b0, 1'b0, 3'd1, 1'b1, 8'd0, 1'b0});
    tbl.push_back('{1'b0, 2'b11, 3'b111, 1'b0, 1'b0, 3'd2, 1'b1, 8'd0, 1'b0});
    tbl.push_back('{1'b0, 2'b11, 3'b111, 1'b0, 1'b1, 3'd5, 1'b0, 8'd0, 1'b0});
    tbl.push_back('{1'b0, 2'b11, 3'b111, 1'b0, 1'b1, 3'd5, 1'b0, 8'd0, 1'b0});
    tbl.push_back('{1'b0, 2'b11, 3'b111, 1'b0, 1'b1, 3'd5, 1'b0, 8'd0, 1'b0});
    tbl.push_back('{1'b0, 2'b11, 3'b111, 1'b0, 1'b0, 3'd3, 1'b1, 8'd0, 1'b0});
    // Hold freezes a nonzero idle count
    tbl.push_back('{1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 3'd5, 1'b0, 8'd1, 1'b0});
    tbl.push_back('{1'b0, 2'b00, 3'b000, 1'b0, 1'b1, 3'd5, 1'b0, 8'd1, 1'b0});
    tbl.push_back('{1'b0, 2'b00, 3'b000, 1'b0, 1'b1, 3'd5, 1'b0, 8'd1, 1'b0});
    tbl.push_back('{1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 3'd5, 1'b0, 8'd2, 1'b0});
    tbl.push_back('{1'b0, 2'b01, 3'b000, 1'b0, 1'b0, 3'd0, 1'b1, 8'd0, 1'b0});

    @(negedge clk);
    foreach (tbl[i]) begin
      if (tbl[i].rst)
        do_reset();
      apply(tbl[i].in_req, tbl[i].gate, tbl[i].mode, tbl[i].hold,
            tbl[i].fire, tbl[i].valid, tbl[i].idle, tbl[i].dl);
    end

    // Mid-cycle reset: set deadlock, advance to fire=2, then reset
    do_reset();
    for (int i = 1; i <= 4; i++)
      apply(2'b00, 3'b000, 1'b0, 1'b0, 3'd5, 1'b0, 8'(i), (i == 4));
    apply(2'b11, 3'b111, 1'b0, 1'b0, 3'd0, 1'b1, 8'd0, 1'b1);
    apply(2'b11, 3'b111, 1'b0, 1'b0, 3'd1, 1'b1, 8'd0, 1'b1);
    #1;
    chk("pre_rst_fire", 32'(fire), 2);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_fire", 32'(fire), 5);
    chk("mid_rst_valid", 32'(fire_valid), 0);
    chk("mid_rst_dl", 32'(deadlock), 0);
    chk("mid_rst_idle", 32'(idle_cnt), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    apply(2'b11, 3'b111, 1'b0, 1'b0, 3'd0, 1'b1, 8'd0, 1'b0);

    // Single enabled stateful gate wins regardless of LFSR start
    for (int i = 0; i < 20; i++)
      apply(2'b00, 3'b100, 1'b1, 1'b0, 3'd4, 1'b1, 8'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
